// File: rtl/neuron_mac.sv
// ----------------------------------------------------------------------------
// neuron_mac
//   Serial multiply-accumulate neuron. A start pulse loads a signed bias, then
//   N_INPUTS (activation, weight) pairs arrive over a valid/ready stream and
//   their products are added to the bias. The finished ACC_W-bit signed sum
//   is held on a valid/ready output until the downstream Activation stage
//   takes it.
//
//   Build option:
//     NEURON_MAC_SATURATE_EN  defined   -> every add clamps to the ACC_W
//                                          signed range, and later terms add
//                                          to the clamped value
//                             undefined -> plain two's-complement wrap
// ----------------------------------------------------------------------------
module neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int X_W      = 5,
    parameter int W_W      = 5,
    parameter int ACC_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [X_W-1:0]   x_in,
    input  logic [W_W-1:0]   w_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy
);

    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    // The activation gets a zero sign bit, so the exact product needs
    // X_W + 1 + W_W bits.
    localparam int PROD_W = X_W + 1 + W_W;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     beat;

    // Adds one sign-extended product to the running sum, either clamping
    // at the signed limits or wrapping modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [PROD_W-1:0] p
    );
`ifdef NEURON_MAC_SATURATE_EN
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(a) + (ACC_W+1)'(p);
        // The two top bits disagree only when the true sum left the
        // ACC_W range; the top bit then gives the direction.
        if (s[ACC_W] != s[ACC_W-1]) begin
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return s[ACC_W-1:0];
`else
        return a + ACC_W'(p);
`endif
    endfunction

    // Signed product of the zero-extended activation and the weight.
    assign prod    = PROD_W'($signed({1'b0, x_in})) * PROD_W'($signed(w_in));
    assign acc_sum = acc_add(acc, prod);

    // One pair is consumed on every handshake while accumulating.
    assign beat = in_valid && (state == ACCUM);

    // Outputs decode directly from registered state, so an async reset
    // clears them immediately.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign acc_out   = acc;

    // Next-state, accumulator and counter update.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt   = bias;
                    cnt_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_nxt = acc_sum;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // The result leaves on out_ready; a simultaneous start
                // begins the next evaluation without an idle cycle.
                if (out_ready) begin
                    if (start) begin
                        acc_nxt   = bias;
                        cnt_nxt   = '0;
                        state_nxt = ACCUM;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, accumulator and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// ----------------------------------------------------------------------------
// tb_neuron_mac
//   Scoreboard bench for neuron_mac. Expected sums are queued when an
//   evaluation is started and compared when the output handshake happens.
//   Build with +define+NEURON_MAC_SATURATE_EN to exercise the clamping build.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neuron_mac;

    localparam int N  = 4;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] bias;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    x_in;
    logic [4:0]    w_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          busy;

    neuron_mac #(.N_INPUTS(N), .X_W(5), .W_W(5), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .w_in      (w_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            total     = 0;
    int            bad       = 0;
    int            n_pushed  = 0;
    int            n_results = 0;
    int            cyc       = 0;
    logic [AW-1:0] sb[$];
    logic [4:0]    px[N];
    logic [4:0]    pw[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output side of the scoreboard: one pop per accepted result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_results++;
            if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
            else                check("result", acc_out, sb.pop_front());
        end
    end

    // Reference sum built from the current pair table.
    function automatic logic [AW-1:0] model(input int b);
        int s;
        logic signed [AW-1:0] t;
        s = b;
        for (int i = 0; i < N; i++) begin
            s += int'(px[i]) * int'($signed(pw[i]));
`ifdef NEURON_MAC_SATURATE_EN
            if (s > 2047)  s = 2047;
            if (s < -2048) s = -2048;
`else
            t = s[AW-1:0];
            s = int'(t);
`endif
        end
        return s[AW-1:0];
    endfunction

    task automatic push_exp(input logic [AW-1:0] e);
        sb.push_back(e);
        n_pushed++;
    endtask

    // Entered and left at 1 ns after a rising edge; start is taken from IDLE.
    task automatic do_start(input logic [AW-1:0] b);
        start = 1'b1;
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
        bias  = $urandom;
    endtask

    // Presents the first n pairs of the table, with optional random idle gaps.
    task automatic send_pairs(input int n, input int gap_pct);
        int  wait_n;
        bit  rdy;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                x_in     = $urandom;
                w_in     = $urandom;
                repeat ($urandom_range(3, 1)) begin
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            x_in     = px[i];
            w_in     = pw[i];
            wait_n   = 0;
            do begin
                @(negedge clk);
                rdy = in_ready;
                wait_n++;
            end while (!rdy && wait_n < 50);
            if (!rdy) check("in_ready_timeout", 32'(rdy), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    // Returns on the falling edge where out_valid is first seen.
    task automatic wait_out_valid(input string tag);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic load_basic();
        px = '{5'd1, 5'd2, 5'd4, 5'd15};
        pw = '{5'd1, 5'd3, 5'h1F, 5'd2};
    endtask

    task automatic run_eval(input logic [AW-1:0] b, input logic [AW-1:0] e, input int gap_pct);
        push_exp(e);
        do_start(b);
        send_pairs(N, gap_pct);
        wait_out_valid("eval");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int lat;

        rst_n     = 1'b0;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        x_in      = '0;
        w_in      = '0;
        out_ready = 1'b1;

        #3;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_acc_out",   32'(acc_out),   32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sum with in_valid held high, plus start-to-out_valid latency.
        load_basic();
        push_exp(12'h021);
        do_start(12'd0);
        k = cyc;
        lat = 0;
        fork
            send_pairs(N, 0);
            begin
                wait_out_valid("basic");
                lat = cyc - k + 1;
            end
        join
        check("basic_latency", 32'(lat), 32'd5);
        @(posedge clk); #1;

        // Negative terms.
        px = '{5'd15, 5'd15, 5'd15, 5'd15};
        pw = '{5'h10, 5'h10, 5'h10, 5'h10};
        run_eval(12'hF9C, 12'hBDC, 0);

        // Overflow in both directions.
        pw = '{5'd15, 5'd15, 5'd15, 5'd15};
`ifdef NEURON_MAC_SATURATE_EN
        run_eval(12'd2000, 12'h7FF, 0);
`else
        run_eval(12'd2000, 12'hB54, 0);
`endif
        pw = '{5'h10, 5'h10, 5'h10, 5'h10};
`ifdef NEURON_MAC_SATURATE_EN
        run_eval(12'h830, 12'h800, 0);
`else
        run_eval(12'h830, 12'h470, 0);
`endif

        // Backpressure: input gaps, output held for 5 cycles, junk pair offered in DONE.
        load_basic();
        out_ready = 1'b0;
        push_exp(12'h021);
        do_start(12'd0);
        send_pairs(N, 50);
        wait_out_valid("bp");
        in_valid = 1'b1;
        x_in     = 5'd31;
        w_in     = 5'd15;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_acc_out",   32'(acc_out),   32'h021);
            check("bp_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_idle_busy", 32'(busy), 32'd0);

        // Back-to-back: take result and start the next one in the same cycle.
        load_basic();
        out_ready = 1'b0;
        push_exp(12'h021);
        do_start(12'd0);
        send_pairs(N, 0);
        wait_out_valid("b2b_first");
        @(posedge clk); #1;
        push_exp(12'h007);
        out_ready = 1'b1;
        start     = 1'b1;
        bias      = 12'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_restart_busy", 32'(in_ready), 32'd1);
        px = '{5'd0, 5'd0, 5'd0, 5'd0};
        pw = '{5'h1F, 5'd9, 5'h10, 5'd15};
        send_pairs(N, 0);
        wait_out_valid("b2b_second");
        @(posedge clk); #1;

        // Reset in the middle of an evaluation.
        load_basic();
        do_start(12'd100);
        send_pairs(2, 0);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_acc_out",   32'(acc_out),   32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_eval(12'd0, 12'h021, 0);

        // Random pairs and biases against the reference model.
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] b;
            b = $urandom;
            for (int i = 0; i < N; i++) begin
                px[i] = $urandom;
                pw[i] = $urandom;
            end
            run_eval(b, model(int'($signed(b))), 30);
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_left_over",  32'(sb.size()), 32'd0);
        check("result_count",  32'(n_results), 32'(n_pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
